serial_link_raw_mode_trainer: RTL



---
 rtl/serial_link_pkg.sv | 32 +++
 rtl/serial_link_raw_mode_trainer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared link types, trainer state encoding and training pattern generator.
package serial_link_pkg;

    localparam int NumChannels      = 4;
    localparam int RawModeFifoDepth = 8;
    localparam int MaxDataWidth     = 64;

    typedef logic [7:0] phy_data_t;

    typedef enum logic [2:0] {
        Idle,
        Flush,
        Send,
        Recv,
        Drain,
        Exit
    } trainer_state_e;

    // Alternating 01/10 background per word index, with the upper index bits XORed in low.
    function automatic logic [MaxDataWidth-1:0] serial_link_train_pattern(input int unsigned k,
                                                                          input int unsigned w);
        logic [MaxDataWidth-1:0] p;
        logic [MaxDataWidth-1:0] s;
        p = '0;
        s = MaxDataWidth'(k >> 1);
        for (int i = 0; i < MaxDataWidth; i++) begin
            if (i < int'(w)) p[i] = (k[0] ? i[0] : ~i[0]) ^ s[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/serial_link_raw_mode_trainer.sv
// serial_link_raw_mode_trainer: raw-mode link training sequencer that sends, reads back and
// qualifies a pattern burst on every channel and reports a per-channel good mask.
module serial_link_raw_mode_trainer
    import serial_link_pkg::*;
#(
    parameter int  NumChannels      = serial_link_pkg::NumChannels,
    parameter type phy_data_t       = serial_link_pkg::phy_data_t,
    parameter int  NumPatterns      = 8,
    parameter int  TimeoutCycles    = 1024,
    parameter int  RawModeFifoDepth = serial_link_pkg::RawModeFifoDepth,
    localparam int W  = $bits(phy_data_t),
    localparam int CW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int FW = $clog2(RawModeFifoDepth)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NumChannels-1:0] chan_good_o,
    output logic                   cfg_raw_mode_en_o,
    output logic                   cfg_flow_control_fifo_clear_o,
    output logic                   cfg_raw_mode_out_data_fifo_clear_o,
    output logic [NumChannels-1:0] cfg_raw_mode_out_ch_mask_o,
    output logic                   cfg_raw_mode_out_en_o,
    output logic [W-1:0]           cfg_raw_mode_out_data_o,
    output logic                   cfg_raw_mode_out_data_valid_o,
    input  logic                   cfg_raw_mode_out_data_fifo_is_full_i,
    input  logic [FW-1:0]          cfg_raw_mode_out_data_fifo_fill_state_i,
    output logic [CW-1:0]          cfg_raw_mode_in_ch_sel_o,
    output logic                   cfg_raw_mode_in_data_ready_o,
    input  logic [W-1:0]           cfg_raw_mode_in_data_i,
    input  logic [NumChannels-1:0] cfg_raw_mode_in_data_valid_i
);

    localparam int KW = $clog2(NumPatterns);
    localparam int TW = $clog2(TimeoutCycles + 1);

    trainer_state_e         state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [NumChannels-1:0] to_q, to_d;
    logic [NumChannels-1:0] good_q, good_d;
    logic                   adv;
    logic                   last_k, last_ch, tmo;
    logic [TW-1:0]          tcnt_inc;
    logic [W-1:0]           pat_q, pat_d;
    logic                   tx_d;

    logic                   busy_q, done_q, raw_en_q, flow_clr_q, out_clr_q, out_en_q;
    logic                   valid_q, ready_q;
    logic [NumChannels-1:0] mask_q;
    logic [W-1:0]           data_q;
    logic [CW-1:0]          sel_q;

    assign last_k   = k_q == KW'(NumPatterns - 1);
    assign last_ch  = ch_q == CW'(NumChannels - 1);
    assign tmo      = tcnt_q == TW'(TimeoutCycles - 1);
    assign tcnt_inc = (tcnt_q == TW'(TimeoutCycles)) ? tcnt_q : tcnt_q + 1'b1;
    assign pat_q    = W'(serial_link_train_pattern(32'(k_q), W));
    assign pat_d    = W'(serial_link_train_pattern(32'(k_d), W));
    assign tx_d     = state_d inside {Send, Recv, Drain};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ch_d    = ch_q;
        tcnt_d  = tcnt_q;
        to_d    = to_q;
        good_d  = good_q;
        adv     = 1'b0;
        case (state_q)
            Idle: begin
                if (start_i) begin
                    good_d  = '1;
                    to_d    = '0;
                    state_d = Flush;
                end
            end
            Flush: begin
                k_d     = '0;
                state_d = Send;
            end
            Send: begin
                if (!cfg_raw_mode_out_data_fifo_is_full_i) begin
                    k_d = last_k ? '0 : k_q + 1'b1;
                    if (last_k) begin
                        ch_d    = '0;
                        tcnt_d  = '0;
                        state_d = Recv;
                    end
                end
            end
            Recv: begin
                if (to_q[ch_q]) begin
                    adv = 1'b1;
                end else if (cfg_raw_mode_in_data_valid_i[ch_q]) begin
                    if (cfg_raw_mode_in_data_i != pat_q) good_d[ch_q] = 1'b0;
                    adv = 1'b1;
                end else if (tmo) begin
                    to_d[ch_q]   = 1'b1;
                    good_d[ch_q] = 1'b0;
                    adv          = 1'b1;
                end else begin
                    tcnt_d = tcnt_inc;
                end
                if (adv) begin
                    tcnt_d = '0;
                    ch_d   = last_ch ? '0 : ch_q + 1'b1;
                    if (last_ch) begin
                        k_d     = last_k ? '0 : k_q + 1'b1;
                        state_d = last_k ? Drain : Recv;
                    end
                end
            end
            Drain: begin
                if (cfg_raw_mode_out_data_fifo_fill_state_i == '0 &&
                    !cfg_raw_mode_out_data_fifo_is_full_i) begin
                    state_d = Exit;
                end else if (tmo) begin
                    good_d  = '0;
                    state_d = Exit;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            Exit:    state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= Idle;
            k_q        <= '0;
            ch_q       <= '0;
            tcnt_q     <= '0;
            to_q       <= '0;
            good_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            raw_en_q   <= 1'b0;
            flow_clr_q <= 1'b0;
            out_clr_q  <= 1'b0;
            mask_q     <= '0;
            out_en_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sel_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ch_q       <= ch_d;
            tcnt_q     <= tcnt_d;
            to_q       <= to_d;
            good_q     <= good_d;
            busy_q     <= state_d != Idle;
            done_q     <= state_d == Exit;
            raw_en_q   <= state_d inside {Flush, Send, Recv, Drain};
            flow_clr_q <= state_d == Exit;
            out_clr_q  <= state_d == Flush;
            mask_q     <= tx_d ? '1 : '0;
            out_en_q   <= tx_d;
            data_q     <= (state_d == Send) ? pat_d : '0;
            valid_q    <= state_d == Send;
            sel_q      <= (state_d == Recv) ? ch_d : '0;
            ready_q    <= state_d == Recv && !to_d[ch_d];
        end
    end

    assign busy_o                             = busy_q;
    assign done_o                             = done_q;
    assign chan_good_o                        = good_q;
    assign cfg_raw_mode_en_o                  = raw_en_q;
    assign cfg_flow_control_fifo_clear_o      = flow_clr_q;
    assign cfg_raw_mode_out_data_fifo_clear_o = out_clr_q;
    assign cfg_raw_mode_out_ch_mask_o         = mask_q;
    assign cfg_raw_mode_out_en_o              = out_en_q;
    assign cfg_raw_mode_out_data_o            = data_q;
    assign cfg_raw_mode_out_data_valid_o      = valid_q;
    assign cfg_raw_mode_in_ch_sel_o           = sel_q;
    assign cfg_raw_mode_in_data_ready_o       = ready_q;

endmodule
